// File: rtl/icache_pkg.sv
// Shared types and address helpers for the instruction-cache miss controller.
// Geometry defaults match the 128 x 64-bit direct-mapped array.
package icache_pkg;

   localparam int ICACHE_IDX_W    = 7;
   localparam int ICACHE_TAG_W    = 22;
   localparam int ICACHE_MEMTAG_W = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_cmd_e;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_e;

   // Field extractors return the field right-justified; callers cast to width.
   function automatic logic [63:0] addr_idx(input logic [63:0] addr, input int idx_w);
      return (addr >> 3) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int idx_w,
                                            input int tag_w);
      return (addr >> (3 + idx_w)) & ((64'd1 << tag_w) - 64'd1);
   endfunction

   function automatic logic [63:0] addr_align(input logic [63:0] addr);
      return {addr[63:3], 3'b000};
   endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Blocking miss controller: combinational hit path, one outstanding BUS_LOAD,
// single-cycle array fill when the tagged response returns.
module icache_ctrl
   import icache_pkg::*;
#(
   parameter int IDX_W    = ICACHE_IDX_W,
   parameter int TAG_W    = ICACHE_TAG_W,
   parameter int MEMTAG_W = ICACHE_MEMTAG_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                proc2Icache_valid,
   input  logic [63:0]         proc2Icache_addr,
   output logic [63:0]         Icache_data_out,
   output logic                Icache_valid_out,
   output logic [IDX_W-1:0]    rd_idx,
   output logic [TAG_W-1:0]    rd_tag,
   input  logic [63:0]         cachemem_data,
   input  logic                cachemem_valid,
   output logic                wr_en,
   output logic [IDX_W-1:0]    wr_idx,
   output logic [TAG_W-1:0]    wr_tag,
   output logic [63:0]         wr_data,
   output logic [1:0]          proc2mem_command,
   output logic [63:0]         proc2mem_addr,
   input  logic [MEMTAG_W-1:0] mem2proc_response,
   input  logic [MEMTAG_W-1:0] mem2proc_tag,
   input  logic [63:0]         mem2proc_data,
   output logic [31:0]         miss_count
);

   state_e                r_state;
   state_e                w_next_state;
   logic [63:0]           r_pending_addr;
   logic [MEMTAG_W-1:0]   r_pending_memtag;
   logic [31:0]           r_miss_count;

   logic [63:0]           w_addr_aligned;
   logic                  w_miss;
   logic                  w_grant;
   logic                  w_withdraw;
   logic                  w_fill;

   assign w_addr_aligned   = addr_align(proc2Icache_addr);
   assign rd_idx           = IDX_W'(addr_idx(proc2Icache_addr, IDX_W));
   assign rd_tag           = TAG_W'(addr_tag(proc2Icache_addr, IDX_W, TAG_W));
   assign Icache_valid_out = proc2Icache_valid & cachemem_valid;
   assign Icache_data_out  = cachemem_data;

   assign w_miss     = proc2Icache_valid & ~cachemem_valid;
   assign w_grant    = (mem2proc_response != '0);
   assign w_withdraw = ~proc2Icache_valid | (w_addr_aligned != r_pending_addr);
   // A zero pending tag never matches, so stale returns after reset are dropped.
   assign w_fill     = (r_state == WAIT) && (r_pending_memtag != '0) &&
                       (mem2proc_tag == r_pending_memtag);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every combinational output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_miss) w_next_state = REQ;
         REQ: begin
            if (w_grant)         w_next_state = WAIT;
            else if (w_withdraw) w_next_state = IDLE;
         end
         WAIT:    if (w_fill) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      proc2mem_command = BUS_NONE;
      wr_en            = 1'b0;
      case (r_state)
         REQ:     proc2mem_command = BUS_LOAD;
         WAIT:    wr_en = w_fill;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pending_addr   <= '0;
         r_pending_memtag <= '0;
         r_miss_count     <= '0;
      end else begin
         if (r_state == IDLE && w_miss) r_pending_addr <= w_addr_aligned;
         if (r_state == REQ && w_grant) begin
            r_pending_memtag <= mem2proc_response;
            r_miss_count     <= r_miss_count + 32'd1;
         end else if (w_fill) begin
            r_pending_memtag <= '0;
         end
      end
   end

   assign proc2mem_addr = r_pending_addr;
   assign wr_idx        = IDX_W'(addr_idx(r_pending_addr, IDX_W));
   assign wr_tag        = TAG_W'(addr_tag(r_pending_addr, IDX_W, TAG_W));
   assign wr_data       = mem2proc_data;
   assign miss_count    = r_miss_count;

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Blocking miss controller for the 128-entry x 64-bit direct-mapped cache memory array. Serves fetch-stage read requests.
- Drives the array's read port combinationally for hit detection. On a miss, issues one BUS_LOAD to the tagged memory bus, waits for the matching tagged response, then writes the returned line into the array.
- Sits between the fetch stage, the cache array and the memory bus.

Parameters:
- IDX_W, 7, cache index width; index = addr[IDX_W+2:3]
- TAG_W, 22, cache tag width; tag = addr[TAG_W+IDX_W+2:IDX_W+3]
- MEMTAG_W, 4, memory transaction tag width; value 0 means "no transaction"

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- proc2Icache_valid  in  1  fetch request present this cycle
- proc2Icache_addr  in  64  fetch byte address
- Icache_data_out  out  64  hit data (cachemem_data passthrough)
- Icache_valid_out  out  1  hit this cycle
- rd_idx / rd_tag  out  IDX_W / TAG_W  array read index and compare tag, decoded from proc2Icache_addr
- cachemem_data  in  64  array read data
- cachemem_valid  in  1  array valid-and-tag-match
- wr_en  out  1  array write enable
- wr_idx / wr_tag  out  IDX_W / TAG_W  fill index and tag
- wr_data  out  64  fill data
- proc2mem_command  out  2  BUS_NONE / BUS_LOAD
- proc2mem_addr  out  64  miss address, bits [2:0] forced to 0
- mem2proc_response  in  MEMTAG_W  transaction tag granted for this cycle's command; 0 = rejected
- mem2proc_tag  in  MEMTAG_W  tag of data returning this cycle; 0 = none
- mem2proc_data  in  64  returning data
- miss_count  out  32  number of accepted miss requests, wraps at 2^32

Behaviour:
- Hit path is fully combinational:
  - Icache_valid_out = proc2Icache_valid & cachemem_valid.
  - Icache_data_out = cachemem_data.
  - Hit latency is 0 cycles in every state.
- State register, reset to IDLE; pending_addr, pending_memtag and miss_count reset to 0.
- IDLE:
  - Outputs: command BUS_NONE, wr_en 0.
  - If proc2Icache_valid & !cachemem_valid: latch the aligned address into pending_addr and go to REQ.
- REQ:
  - Outputs: command BUS_LOAD, proc2mem_addr = pending_addr.
  - If mem2proc_response != 0: latch it into pending_memtag, increment miss_count, go to WAIT.
  - Else, if proc2Icache_valid = 0 or the decoded address no longer equals pending_addr (redirect): go to IDLE with no transaction issued.
  - Else: stay in REQ and retry next cycle.
  - A grant in the same cycle as a withdrawal is honoured (go to WAIT).
- WAIT:
  - Outputs: command BUS_NONE.
  - When mem2proc_tag == pending_memtag (nonzero): drive wr_en = 1 for exactly one cycle with wr_idx/wr_tag from pending_addr and wr_data = mem2proc_data; clear pending_memtag; go to IDLE.
  - The fill always completes, even if fetch was redirected. A request for the filled line hits on the cycle after the write.
  - Non-matching mem2proc_tag values are ignored.
- Only one outstanding miss exists at a time; new misses are not serviced until IDLE.
- A miss detected in IDLE on the cycle after a fill is a new miss; no bypass of fill data to the output.
- Reset in any state:
  - Returns to IDLE and clears pending_memtag.
  - A late response for a transaction issued before reset is ignored and never written.
- wr_en is 0 in IDLE and REQ, and in WAIT except on the matching cycle.

Decomposition:
- Shared package `icache_pkg`:
  - BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2
  - state enum IDLE / REQ / WAIT
  - address-slicing helper functions for idx and tag
- No sub-module needed. miss_count stays inline; the single-state-machine controller is the whole block.

Test Plan:
- Hit: reset, then preload idx 5 / tag 0x3 via the array, request addr 0xC28 -> Icache_valid_out = 1 with the stored data the same cycle; command stays BUS_NONE; miss_count = 0.
- Miss and fill: request addr 0x1000 on a cold cache, memory grants tag 3 on the first REQ cycle and returns data 0xDEADBEEF with tag 3 four cycles later -> one BUS_LOAD at 0x1000; wr_en pulses one cycle with idx 0, tag 0x4; a hit follows the next cycle; miss_count = 1.
- Rejection retry: mem2proc_response = 0 for 3 cycles, then 7 -> BUS_LOAD held for 4 cycles at the same address; pending tag 7; miss_count = 1.
- Redirect: miss on 0x2000 rejected, then addr changes to 0x3000 -> return to IDLE, then a new miss at 0x3000. If instead granted in WAIT, the 0x2000 fill still writes the array.
- Foreign and early tags: in WAIT with pending tag 2, mem2proc_tag = 5 then 2 -> the array is written only on the tag-2 cycle.
- Reset mid-WAIT: assert reset in WAIT (tag 4), then mem2proc_tag = 4 after reset -> wr_en stays 0, state IDLE, miss_count = 0.
